// File: rtl/trap_csr_unit.sv
// trap_csr_unit: machine-mode trap entry, mret and CSR file for a single-hart RV32 core.
// Ports: clk/rst (sync, active-high); i_valid/i_pc retiring instruction; i_causeNum/i_exception/i_mret
// from the exception decoder; i_csrOp/i_csrAddr/i_csrWdata CSR access; o_csrRdata combinational old
// CSR value; o_redirect/o_redirectPc registered one-cycle fetch redirect.
module trap_csr_unit #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
    parameter logic [31:0] HART_ID     = 32'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_valid,
    input  logic [31:0] i_pc,
    input  logic [3:0]  i_causeNum,
    input  logic        i_exception,
    input  logic        i_mret,
    input  logic [1:0]  i_csrOp,
    input  logic [11:0] i_csrAddr,
    input  logic [31:0] i_csrWdata,
    output logic [31:0] o_csrRdata,
    output logic        o_redirect,
    output logic [31:0] o_redirectPc
);
    logic        mie_q, mie_d, mpie_q, mpie_d;
    logic [31:0] mtvec_q, mtvec_d, mscratch_q, mscratch_d, mepc_q, mepc_d, mcause_q, mcause_d;
    logic [63:0] mcycle_q, mcycle_d, minstret_q, minstret_d;
    logic        redirect_q, redirect_d;
    logic [31:0] redirect_pc_q, redirect_pc_d;
    logic        act, trap, do_mret, csr_we;
    logic [31:0] new_val;

    always_comb begin
        // The instruction presented during a redirect is the squashed shadow.
        act     = i_valid & ~redirect_q;
        trap    = act & i_exception;
        do_mret = act & i_mret & ~i_exception;
        case (i_csrAddr)
            12'h300: o_csrRdata = {19'b0, 2'b11, 3'b0, mpie_q, 3'b0, mie_q, 3'b0};
            12'h305: o_csrRdata = mtvec_q;
            12'h340: o_csrRdata = mscratch_q;
            12'h341: o_csrRdata = mepc_q;
            12'h342: o_csrRdata = mcause_q;
            12'hF14: o_csrRdata = HART_ID;
            12'hB00: o_csrRdata = mcycle_q[31:0];
            12'hB80: o_csrRdata = mcycle_q[63:32];
            12'hB02: o_csrRdata = minstret_q[31:0];
            12'hB82: o_csrRdata = minstret_q[63:32];
            default: o_csrRdata = 32'h0;
        endcase
        new_val = (i_csrOp == 2'b01) ? i_csrWdata :
                  (i_csrOp == 2'b10) ? (o_csrRdata | i_csrWdata) : (o_csrRdata & ~i_csrWdata);
        // Set/clear with a zero mask is a pure read.
        csr_we  = act & ~i_exception & ~i_mret & (i_csrOp != 2'b00) &
                  ((i_csrOp == 2'b01) | (i_csrWdata != 32'h0));
        mie_d       = mie_q;
        mpie_d      = mpie_q;
        mtvec_d     = mtvec_q;
        mscratch_d  = mscratch_q;
        mepc_d      = mepc_q;
        mcause_d    = mcause_q;
        mcycle_d    = mcycle_q + 64'd1;
        minstret_d  = minstret_q + {63'b0, act & ~i_exception};
        if (csr_we) begin
            case (i_csrAddr)
                12'h300: begin
                    mie_d  = new_val[3];
                    mpie_d = new_val[7];
                end
                12'h305: mtvec_d    = new_val & ~32'h3;
                12'h340: mscratch_d = new_val;
                12'h341: mepc_d     = new_val & ~32'h3;
                12'h342: mcause_d   = new_val;
                // A write to either half freezes the whole counter for this cycle.
                12'hB00: mcycle_d   = {mcycle_q[63:32], new_val};
                12'hB80: mcycle_d   = {new_val, mcycle_q[31:0]};
                12'hB02: minstret_d = {minstret_q[63:32], new_val};
                12'hB82: minstret_d = {new_val, minstret_q[31:0]};
                default: ;
            endcase
        end
        if (trap) begin
            mepc_d   = i_pc & ~32'h3;
            mcause_d = {28'b0, i_causeNum};
            mpie_d   = mie_q;
            mie_d    = 1'b0;
        end
        if (do_mret) begin
            mie_d  = mpie_q;
            mpie_d = 1'b1;
        end
        redirect_d    = trap | do_mret;
        redirect_pc_d = trap ? mtvec_q : do_mret ? mepc_q : redirect_pc_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mie_q         <= 1'b0;
            mpie_q        <= 1'b0;
            mtvec_q       <= RESET_MTVEC & ~32'h3;
            mscratch_q    <= 32'h0;
            mepc_q        <= 32'h0;
            mcause_q      <= 32'h0;
            mcycle_q      <= 64'h0;
            minstret_q    <= 64'h0;
            redirect_q    <= 1'b0;
            redirect_pc_q <= 32'h0;
        end else begin
            mie_q         <= mie_d;
            mpie_q        <= mpie_d;
            mtvec_q       <= mtvec_d;
            mscratch_q    <= mscratch_d;
            mepc_q        <= mepc_d;
            mcause_q      <= mcause_d;
            mcycle_q      <= mcycle_d;
            minstret_q    <= minstret_d;
            redirect_q    <= redirect_d;
            redirect_pc_q <= redirect_pc_d;
        end
    end

    assign o_redirect   = redirect_q;
    assign o_redirectPc = redirect_pc_q;
endmodule

// File: tb/tb_trap_csr_unit.sv
// tb_trap_csr_unit: directed self-checking bench for trap_csr_unit.
module tb_trap_csr_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic [31:0] i_pc = 32'h0;
    logic [3:0]  i_causeNum = 4'h0;
    logic        i_exception = 1'b0;
    logic        i_mret = 1'b0;
    logic [1:0]  i_csrOp = 2'b00;
    logic [11:0] i_csrAddr = 12'h0;
    logic [31:0] i_csrWdata = 32'h0;
    logic [31:0] o_csrRdata;
    logic        o_redirect;
    logic [31:0] o_redirectPc;
    int          tests = 0;
    int          fails = 0;
    logic [31:0] rd_old, rv, ir0, ms0;

    trap_csr_unit #(.RESET_MTVEC(32'h0000_0103), .HART_ID(32'd0)) dut (
        .clk(clk), .rst(rst), .i_valid(i_valid), .i_pc(i_pc), .i_causeNum(i_causeNum),
        .i_exception(i_exception), .i_mret(i_mret), .i_csrOp(i_csrOp), .i_csrAddr(i_csrAddr),
        .i_csrWdata(i_csrWdata), .o_csrRdata(o_csrRdata), .o_redirect(o_redirect),
        .o_redirectPc(o_redirectPc)
    );

    always #5 clk = ~clk;

    // Present one instruction, capture the pre-edge read value, and return 1ns after the edge.
    task automatic issue(input logic v, input logic [31:0] pc, input logic [3:0] cause,
                         input logic exc, input logic mr, input logic [1:0] op,
                         input logic [11:0] addr, input logic [31:0] wd);
        i_valid = v; i_pc = pc; i_causeNum = cause; i_exception = exc; i_mret = mr;
        i_csrOp = op; i_csrAddr = addr; i_csrWdata = wd;
        #1 rd_old = o_csrRdata;
        @(posedge clk);
        #1;
        i_valid = 1'b0; i_exception = 1'b0; i_mret = 1'b0; i_csrOp = 2'b00; i_csrWdata = 32'h0;
    endtask

    task automatic wr(input logic [11:0] addr, input logic [31:0] val);
        issue(1'b1, 32'h100, 4'h0, 1'b0, 1'b0, 2'b01, addr, val);
    endtask

    task automatic rd(input logic [11:0] addr);
        i_csrAddr = addr;
        #1 rv = o_csrRdata;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        rd(12'hB00);
        tests++; if (rv !== 32'h0) begin fails++; $display("FAIL reset_mcycle got %h exp %h", rv, 32'h0); end
        rd(12'h305);
        tests++; if (rv !== 32'h100) begin fails++; $display("FAIL reset_mtvec got %h exp %h", rv, 32'h100); end
        rd(12'h300);
        tests++; if (rv !== 32'h1800) begin fails++; $display("FAIL reset_mstatus got %h exp %h", rv, 32'h1800); end
        tests++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL reset_redirect got %b exp 0", o_redirect); end
        tests++; if (o_redirectPc !== 32'h0) begin fails++; $display("FAIL reset_redirect_pc got %h exp 0", o_redirectPc); end
    endtask

    task automatic test_trap;
        wr(12'h300, 32'h8);
        wr(12'h305, 32'h200);
        rd(12'hB02); ir0 = rv;
        issue(1'b1, 32'h1004, 4'b1000, 1'b1, 1'b0, 2'b00, 12'h0, 32'h0);
        tests++; if (o_redirect !== 1'b1) begin fails++; $display("FAIL trap_redirect got %b exp 1", o_redirect); end
        tests++; if (o_redirectPc !== 32'h200) begin fails++; $display("FAIL trap_pc got %h exp %h", o_redirectPc, 32'h200); end
        rd(12'h341);
        tests++; if (rv !== 32'h1004) begin fails++; $display("FAIL trap_mepc got %h exp %h", rv, 32'h1004); end
        rd(12'h342);
        tests++; if (rv !== 32'h8) begin fails++; $display("FAIL trap_mcause got %h exp %h", rv, 32'h8); end
        rd(12'h300);
        tests++; if (rv !== 32'h1880) begin fails++; $display("FAIL trap_mstatus got %h exp %h", rv, 32'h1880); end
        rd(12'hB02);
        tests++; if (rv !== ir0) begin fails++; $display("FAIL trap_minstret got %h exp %h", rv, ir0); end
    endtask

    task automatic test_shadow;
        rd(12'h340); ms0 = rv;
        issue(1'b1, 32'h1008, 4'h0, 1'b0, 1'b0, 2'b01, 12'h340, 32'hDEAD_BEEF);
        tests++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL shadow_redirect got %b exp 0", o_redirect); end
        rd(12'h340);
        tests++; if (rv !== ms0) begin fails++; $display("FAIL shadow_mscratch got %h exp %h", rv, ms0); end
        rd(12'hB02);
        tests++; if (rv !== ir0) begin fails++; $display("FAIL shadow_minstret got %h exp %h", rv, ir0); end
    endtask

    task automatic test_mret;
        wr(12'h341, 32'h1008);
        wr(12'h300, 32'h80);
        rd(12'hB02); ir0 = rv;
        issue(1'b1, 32'h200, 4'h0, 1'b0, 1'b1, 2'b00, 12'h0, 32'h0);
        tests++; if (o_redirect !== 1'b1) begin fails++; $display("FAIL mret_redirect got %b exp 1", o_redirect); end
        tests++; if (o_redirectPc !== 32'h1008) begin fails++; $display("FAIL mret_pc got %h exp %h", o_redirectPc, 32'h1008); end
        rd(12'h300);
        tests++; if (rv !== 32'h1888) begin fails++; $display("FAIL mret_mstatus got %h exp %h", rv, 32'h1888); end
        rd(12'hB02);
        tests++; if (rv !== ir0 + 32'd1) begin fails++; $display("FAIL mret_minstret got %h exp %h", rv, ir0 + 32'd1); end
        @(posedge clk); #1;
        tests++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL mret_pulse got %b exp 0", o_redirect); end
    endtask

    task automatic test_setclr;
        wr(12'h340, 32'hF0F0_0000);
        issue(1'b1, 32'h100, 4'h0, 1'b0, 1'b0, 2'b10, 12'h340, 32'h0000_000F);
        tests++; if (rd_old !== 32'hF0F0_0000) begin fails++; $display("FAIL csrrs_old got %h exp %h", rd_old, 32'hF0F0_0000); end
        issue(1'b1, 32'h104, 4'h0, 1'b0, 1'b0, 2'b11, 12'h340, 32'hF000_0000);
        tests++; if (rd_old !== 32'hF0F0_000F) begin fails++; $display("FAIL csrrc_old got %h exp %h", rd_old, 32'hF0F0_000F); end
        rd(12'h340);
        tests++; if (rv !== 32'h00F0_000F) begin fails++; $display("FAIL csrrc_final got %h exp %h", rv, 32'h00F0_000F); end
        wr(12'hF14, 32'h55);
        rd(12'hF14);
        tests++; if (rv !== 32'h0) begin fails++; $display("FAIL mhartid_ro got %h exp 0", rv); end
        rd(12'h123);
        tests++; if (rv !== 32'h0) begin fails++; $display("FAIL unimpl_read got %h exp 0", rv); end
    endtask

    task automatic test_counters;
        wr(12'hB00, 32'hFFFF_FFFF);
        wr(12'hB80, 32'h0);
        rd(12'hB00);
        tests++; if (rv !== 32'hFFFF_FFFF) begin fails++; $display("FAIL mcycle_write got %h exp %h", rv, 32'hFFFF_FFFF); end
        rd(12'hB80);
        tests++; if (rv !== 32'h0) begin fails++; $display("FAIL mcycleh_write got %h exp 0", rv); end
        @(posedge clk); #1;
        rd(12'hB00);
        tests++; if (rv !== 32'h0) begin fails++; $display("FAIL mcycle_wrap got %h exp 0", rv); end
        rd(12'hB80);
        tests++; if (rv !== 32'h1) begin fails++; $display("FAIL mcycleh_carry got %h exp 1", rv); end
        rd(12'hB02); ir0 = rv;
        issue(1'b1, 32'h100, 4'h0, 1'b0, 1'b0, 2'b10, 12'hB02, 32'h0);
        tests++; if (rd_old !== ir0) begin fails++; $display("FAIL minstret_read got %h exp %h", rd_old, ir0); end
        rd(12'hB02);
        tests++; if (rv !== ir0 + 32'd1) begin fails++; $display("FAIL minstret_inc got %h exp %h", rv, ir0 + 32'd1); end
        wr(12'hB02, 32'h5);
        wr(12'hB82, 32'h7);
        rd(12'hB02);
        tests++; if (rv !== 32'h5) begin fails++; $display("FAIL minstret_prec got %h exp 5", rv); end
        rd(12'hB82);
        tests++; if (rv !== 32'h7) begin fails++; $display("FAIL minstreth_write got %h exp 7", rv); end
    endtask

    task automatic test_back_to_back;
        wr(12'h305, 32'h303);
        issue(1'b1, 32'h2003, 4'h2, 1'b1, 1'b0, 2'b01, 12'h340, 32'h1234);
        tests++; if (o_redirectPc !== 32'h300) begin fails++; $display("FAIL b2b_mtvec got %h exp %h", o_redirectPc, 32'h300); end
        rd(12'h341);
        tests++; if (rv !== 32'h2000) begin fails++; $display("FAIL b2b_mepc got %h exp %h", rv, 32'h2000); end
        rd(12'h340);
        tests++; if (rv !== 32'h00F0_000F) begin fails++; $display("FAIL trap_csr_suppress got %h exp %h", rv, 32'h00F0_000F); end
        issue(1'b1, 32'h300, 4'h5, 1'b1, 1'b0, 2'b00, 12'h0, 32'h0);
        tests++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL shadow_trap got %b exp 0", o_redirect); end
        rd(12'h342);
        tests++; if (rv !== 32'h2) begin fails++; $display("FAIL shadow_mcause got %h exp 2", rv); end
        issue(1'b1, 32'h3000, 4'hB, 1'b1, 1'b0, 2'b00, 12'h0, 32'h0);
        tests++; if (o_redirect !== 1'b1) begin fails++; $display("FAIL post_shadow_trap got %b exp 1", o_redirect); end
        rd(12'h342);
        tests++; if (rv !== 32'hB) begin fails++; $display("FAIL post_shadow_mcause got %h exp %h", rv, 32'hB); end
        @(posedge clk); #1;
        rst = 1'b1;
        issue(1'b1, 32'h4000, 4'h3, 1'b1, 1'b0, 2'b00, 12'h0, 32'h0);
        rst = 1'b0;
        tests++; if (o_redirect !== 1'b0) begin fails++; $display("FAIL rst_cancel got %b exp 0", o_redirect); end
        rd(12'h305);
        tests++; if (rv !== 32'h100) begin fails++; $display("FAIL rst_mtvec got %h exp %h", rv, 32'h100); end
    endtask

    initial begin
        test_reset;
        test_trap;
        test_shadow;
        test_mret;
        test_setclr;
        test_counters;
        test_back_to_back;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/trap_csr_unit.md
# trap_csr_unit

Machine-mode trap and CSR unit for the single-hart RV32 core. It sits directly downstream of the exception decoder and consumes its `causeNum`/`exception`/`mret` outputs together with the retiring instruction's PC and CSR-access fields. It owns the machine CSRs (mstatus, mtvec, mscratch, mepc, mcause, mhartid, mcycle/minstret) and produces a registered one-cycle PC redirect for trap entry and `mret`.

## Interface
- `RESET_MTVEC`, 32'h0000_0000, reset value of mtvec; bits [1:0] are ignored.
- `HART_ID`, 32'd0, value returned by mhartid.
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  an instruction is retiring this cycle.
- `i_pc`  in  32  PC of the retiring instruction.
- `i_causeNum`  in  4  trap cause from the exception decoder.
- `i_exception`  in  1  the retiring instruction traps.
- `i_mret`  in  1  the retiring instruction is `mret`.
- `i_csrOp`  in  2  CSR access: 00 none, 01 write (csrrw), 10 set (csrrs), 11 clear (csrrc).
- `i_csrAddr`  in  12  CSR address.
- `i_csrWdata`  in  32  rs1 value or zero-extended zimm, already muxed upstream.
- `o_csrRdata`  out  32  combinational old value of the addressed CSR; 0 for unimplemented addresses.
- `o_redirect`  out  1  registered one-cycle pulse: the fetch PC must load `o_redirectPc`.
- `o_redirectPc`  out  32  registered redirect target.

## Operation
- **Effective event.** An event is `act = i_valid & ~o_redirect`. While `o_redirect` is high, the instruction presented is a squashed shadow instruction. It causes no CSR write, no trap, no `mret` action and no minstret increment. `o_csrRdata` still reflects the address.
- **Priority within one `act` cycle:** exception, then `mret`, then CSR access. If `i_exception` is set, the CSR write is suppressed even when `i_csrOp != 00`.
- **Trap entry** (`act & i_exception`):
  - mepc ← `{i_pc[31:2], 2'b00}`.
  - mcause ← `{28'b0, i_causeNum}`; the interrupt bit is always 0.
  - mstatus.MPIE ← MIE, then MIE ← 0.
  - Next cycle: `o_redirect` = 1 and `o_redirectPc` = `{mtvec[31:2], 2'b00}`. Only direct mode is supported.
- **`mret`** (`act & i_mret & ~i_exception`):
  - MIE ← MPIE, then MPIE ← 1.
  - Next cycle: `o_redirect` = 1 and `o_redirectPc` = mepc.
- **CSR access** (`act & ~i_exception & ~i_mret & i_csrOp != 00`):
  - The new value is wdata, old|wdata, or old&~wdata.
  - Set or clear with `i_csrWdata == 0` performs no write.
  - Writes to unimplemented or read-only addresses are ignored.
- **CSR map and field rules:**
  - mstatus 0x300: only MIE[3] and MPIE[7] are writable; MPP[12:11] reads 2'b11; all other bits read 0.
  - mtvec 0x305: bits [1:0] read 0.
  - mscratch 0x340: full 32 bits.
  - mepc 0x341: bits [1:0] read 0.
  - mcause 0x342: full 32 bits writable.
  - mhartid 0xF14: read-only, returns `HART_ID`.
  - mcycle 0xB00 / mcycleh 0xB80: low and high halves of a 64-bit counter.
  - minstret 0xB02 / minstreth 0xB82: low and high halves of a 64-bit counter.
- **Counters:**
  - mcycle increments every cycle that `rst` is low.
  - minstret increments on `act & ~i_exception`. This includes `mret` and CSR instructions.
  - Both counters wrap modulo 2^64. A carry out of the low half increments the high half in the same cycle.
  - A CSR write to either half takes precedence over that cycle's increment for that whole 64-bit counter.
- **Reset:** all CSRs are 0 except mtvec = `RESET_MTVEC` with [1:0] cleared. `o_redirect` = 0 and `o_redirectPc` = 0. Reset mid-trap cancels any pending redirect.

## Timing
- `o_csrRdata` is combinational: the same-cycle old value.
- CSR, mepc, mcause and mstatus updates are visible on `o_csrRdata` from the cycle after the event.
- Redirect latency is 1 cycle after the event; `o_redirect` is high for exactly 1 cycle.
- Back-to-back events are impossible by construction: the shadow cycle is always squashed.
- A trap in the cycle right after the squashed shadow cycle is accepted normally.
- A CSR write to mtvec or mepc in cycle N, followed by a trap or `mret` in cycle N+1, uses the newly written value.

## Test plan
- **Reset.** Stimulus: `rst`=1 for 2 cycles with `RESET_MTVEC`=32'h0000_0103. Required: read 0x305 → 0x0000_0100; `o_redirect`=0; mcycle reads 0 in the first cycle after reset.
- **ecall trap.** Stimulus: mstatus=0x8 (MIE=1), `i_valid`=1, `i_pc`=0x0000_1004, `i_exception`=1, `i_causeNum`=4'b1000, mtvec=0x200. Required next cycle: `o_redirect`=1 and `o_redirectPc`=0x200; mepc=0x1004; mcause=8; mstatus reads 0x1880; minstret unchanged.
- **Shadow squash.** Stimulus: in the redirect cycle, present `i_valid`=1 with csrrw 0x340, wdata 0xDEAD_BEEF. Required: mscratch unchanged; minstret unchanged; no second redirect.
- **mret.** Stimulus: mepc=0x1008, mstatus=0x80, `i_mret`=1. Required next cycle: `o_redirectPc`=0x1008; mstatus reads 0x1888.
- **CSR set/clear.** Stimulus: mscratch=0xF0F0_0000; csrrs with wdata 0x0000_000F; then csrrc with wdata 0xF000_0000. Required: `o_csrRdata` returns the old values 0xF0F0_0000 then 0xF0F0_000F; final mscratch=0x00F0_000F.
- **Counter wrap and write precedence.** Stimulus: write mcycle=0xFFFF_FFFF and mcycleh=0. Required: mcycleh=1 and mcycle=0 one cycle after the low write's value is seen. Stimulus: csrrs minstret with wdata 0. Required: minstret increments normally.
